// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction fetch bus: imem address/data, redirect and decode handoff
//
// Signals:
//   cnt_out        fetch unit -> imem     PC / instruction-memory word address
//   instruction    imem -> fetch unit     combinational read data for cnt_out
//   redirect_valid core -> fetch unit     branch/jump redirect request
//   redirect_addr  core -> fetch unit     redirect target word address
//   if_valid       fetch unit -> decode   if_instr/if_pc hold a fetched instruction
//   dec_ready      decode -> fetch unit   decode accepts the output this cycle
//   if_instr       fetch unit -> decode   fetched instruction
//   if_pc          fetch unit -> decode   word address of if_instr
// Modports: master = fetch unit side, slave = memory/core/decode side.
interface instr_fetch_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
);
    logic [AWIDTH-1:0] cnt_out;
    logic [DWIDTH-1:0] instruction;
    logic              redirect_valid;
    logic [AWIDTH-1:0] redirect_addr;
    logic              if_valid;
    logic              dec_ready;
    logic [DWIDTH-1:0] if_instr;
    logic [AWIDTH-1:0] if_pc;

    modport master (
        output cnt_out, if_valid, if_instr, if_pc,
        input  instruction, redirect_valid, redirect_addr, dec_ready
    );

    modport slave (
        input  cnt_out, if_valid, if_instr, if_pc,
        output instruction, redirect_valid, redirect_addr, dec_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit with PC, stall handling and redirect
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   fetch_en     fetch enable from core control
//   bus          instr_fetch_if.master (imem address/data, redirect, decode handoff)
//   fetch_count  (only with IFETCH_PERF_EN) 32-bit count of decode transfers
//
// Optional feature macro: IFETCH_PERF_EN adds the fetch_count performance counter.
module instr_fetch_unit #(
    parameter int AWIDTH     = 8,
    parameter int DWIDTH     = 32,
    parameter int RESET_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    instr_fetch_if.master       bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]         fetch_count
`endif
);

    localparam logic [AWIDTH-1:0] RST_PC = AWIDTH'(RESET_ADDR);

    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] pc_q;
    logic              valid_q;
    logic [DWIDTH-1:0] instr_q;
    logic [AWIDTH-1:0] ifpc_q;
    logic              load;
    logic              clr_valid;

    assign bus.cnt_out  = pc_q;
    assign bus.if_valid = valid_q;
    assign bus.if_instr = instr_q;
    assign bus.if_pc    = ifpc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_q    <= RST_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= '0;
        end else begin
            state <= state_nxt;
            // Redirect wins over everything: the held instruction is dropped.
            if (bus.redirect_valid) begin
                pc_q    <= bus.redirect_addr;
                valid_q <= 1'b0;
            end else if (load) begin
                instr_q <= bus.instruction;
                ifpc_q  <= pc_q;
                valid_q <= 1'b1;
                pc_q    <= pc_q + 1'b1;
            end else if (clr_valid) begin
                valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clr_valid = 1'b0;
        if (bus.redirect_valid) begin
            state_nxt = fetch_en ? FETCH : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en)
                        state_nxt = FETCH;
                end
                FETCH, STALL: begin
                    if (fetch_en) begin
                        // A new word may replace the held one only if it is consumed now.
                        if (!valid_q || bus.dec_ready) begin
                            load      = 1'b1;
                            state_nxt = FETCH;
                        end else begin
                            state_nxt = STALL;
                        end
                    end else begin
                        // Fetch disabled: let decode drain the held word, then idle.
                        clr_valid = bus.dec_ready;
                        if (!valid_q || bus.dec_ready)
                            state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_count <= '0;
        else if (valid_q && bus.dec_ready)
            fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 8, width of the instruction-memory word address.
REQ-002 SHALL have parameter DWIDTH, default 32, instruction width.
REQ-003 SHALL have parameter RESET_ADDR, default 0, word address loaded into the PC on reset.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 fetch_en  input  1  fetch enable from the core control.
REQ-007 cnt_out  output  AWIDTH  registered PC, drives the instruction-memory address.
REQ-008 instruction  input  DWIDTH  combinational read data returned by instruction memory for cnt_out.
REQ-009 redirect_valid  input  1  branch/jump redirect request.
REQ-010 redirect_addr  input  AWIDTH  redirect target word address.
REQ-011 if_valid  output  1  if_instr/if_pc hold a fetched instruction.
REQ-012 dec_ready  input  1  decode accepts the output in this cycle.
REQ-013 if_instr  output  DWIDTH  registered fetched instruction.
REQ-014 if_pc  output  AWIDTH  word address from which if_instr was fetched.

Function
REQ-015 SHALL implement an FSM with states IDLE, FETCH and STALL.
REQ-016 "load" SHALL mean: if_instr<=instruction, if_pc<=cnt_out, if_valid<=1, cnt_out<=cnt_out+1 modulo 2^AWIDTH.
REQ-017 IDLE: no load; fetch_en=1 -> FETCH next cycle.
REQ-018 FETCH with fetch_en=1: load when if_valid=0 or dec_ready=1; if if_valid=1 and dec_ready=0 -> STALL with all registers held.
REQ-019 STALL: hold cnt_out, if_instr, if_pc, if_valid=1 while dec_ready=0; on dec_ready=1 load in the same cycle and return to FETCH.
REQ-020 A transfer SHALL occur on each cycle with if_valid=1 and dec_ready=1; each fetched word is transferred exactly once, in address order between redirects.
REQ-021 fetch_en=0 in FETCH or STALL: no new load; dec_ready=1 clears if_valid; go to IDLE once if_valid=0 or is cleared that cycle.
REQ-022 Throughput SHALL be one instruction per cycle while fetch_en=1 and dec_ready=1.
REQ-023 Latency: fetch_en sampled 1 in IDLE at edge N -> FETCH; first load at edge N+1, so if_valid=1 with instruction[RESET_ADDR] after edge N+1.
REQ-024 redirect_valid=1 SHALL have priority over stall, fetch_en and load: cnt_out<=redirect_addr, if_valid<=0, the pending instruction is discarded, next state FETCH if fetch_en=1 else IDLE.
REQ-025 Word fetched from redirect_addr SHALL appear on if_instr with if_valid=1 one edge after the redirect edge when fetch_en=1.
REQ-026 PC wrap: cnt_out=2^AWIDTH-1 SHALL increment to 0 without any flag.
REQ-027 if_instr and if_pc SHALL change only on a load or on reset.

Reset
REQ-028 rst_n=0 SHALL immediately force cnt_out=RESET_ADDR, if_valid=0, if_instr=0, if_pc=0, state IDLE, regardless of clk.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; after release the unit waits in IDLE for fetch_en.

Configuration
REQ-030 Macro IFETCH_PERF_EN defined: SHALL add output fetch_count (32 bits), reset 0, +1 per transfer (REQ-020), wrapping at 2^32.
REQ-031 Macro IFETCH_PERF_EN undefined: the fetch_count port and its counter SHALL be absent; all other behaviour unchanged.

Verification
REQ-032 Memory words 0..5 = 00007033, 00208433, 404404B3, 404404B3, 00317533, 0041E5B3; reset, fetch_en=1, dec_ready=1 -> if_instr sequence 00007033, 00208433, 404404B3 on consecutive cycles with if_pc 0,1,2.
REQ-033 dec_ready=0 for 3 cycles while if_pc=1 -> if_instr=00208433 and cnt_out=2 held; dec_ready=1 -> next cycle if_pc=2, if_instr=404404B3, no word lost or duplicated.
REQ-034 redirect_valid=1, redirect_addr=5 while if_valid=1, dec_ready=0 -> next cycle if_valid=0; cycle after, if_pc=5, if_instr=0041E5B3.
REQ-035 redirect to 8'hFF with dec_ready=1 -> if_pc sequence FF, 00, 01; cnt_out wraps to 0.
REQ-036 rst_n pulsed low during STALL -> outputs 0 and cnt_out=RESET_ADDR immediately; with IFETCH_PERF_EN, fetch_count=0 after reset and equals 6 after 6 transfers.
